// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer and flag controller for the async FIFO (wclk domain).
// Latency: pointers and flags update on the accepting edge; read-pointer progress is seen SYNC_STAGES+1 edges later.
// Backpressure: a write is accepted only while full is low; a write attempt while full sets the sticky overflow flag.
//
// Ports:
//   wclk, wrst     write clock, synchronous active-high reset
//   w_en           write request from the producer
//   g_rptr_async   Gray read pointer from the rclk domain (unsynchronised)
//   ovf_clr        clears the sticky overflow flag
//   b_wptr         binary write pointer; the memory address is [PTR_WIDTH-1:0]
//   g_wptr         registered Gray write pointer, exported to the read domain
//   full           FIFO full; gates memory writes
//   almost_full    fill level >= AFULL_THRESH
//   wr_level       occupancy seen from the write side, 0..DEPTH
//   overflow       sticky: a write was attempted while full
//
// DEPTH must equal 2**PTR_WIDTH. PTR_WIDTH must be >= 2 and SYNC_STAGES >= 2.
module fifo_wptr_ctrl #(
    parameter int DEPTH        = 8,
    parameter int PTR_WIDTH    = 3,
    parameter int AFULL_THRESH = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 w_en,
    input  logic [PTR_WIDTH:0]   g_rptr_async,
    input  logic                 ovf_clr,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 overflow
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic                 wr_acc;
    logic [PTR_WIDTH:0]   b_next;
    logic [PTR_WIDTH:0]   g_next;
    logic [PTR_WIDTH:0]   rq;
    logic [PTR_WIDTH:0]   r_bin;
    logic [PTR_WIDTH:0]   level_next;
    logic [PTR_WIDTH:0]   rsync_q [SYNC_STAGES];

    // Accept against the registered full flag so the write decision never
    // depends on a combinational path through the synchroniser.
    assign wr_acc = w_en & ~full;
    assign b_next = b_wptr + {{PTR_WIDTH{1'b0}}, wr_acc};
    assign g_next = b_next ^ (b_next >> 1);

    // Plain flop chain: nothing may sit between the async input and the
    // first stage, otherwise multi-bit glitches could be captured.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rsync_q[i] <= '0;
            end
        end else begin
            rsync_q[0] <= g_rptr_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rsync_q[i] <= rsync_q[i-1];
            end
        end
    end

    assign rq = rsync_q[SYNC_STAGES-1];

    always_comb begin
        r_bin = '0;
        r_bin[PTR_WIDTH] = rq[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            r_bin[i] = r_bin[i+1] ^ rq[i];
        end
    end

    // Difference is taken modulo 2**(PTR_WIDTH+1); the wrap bit makes a
    // completely full FIFO read as DEPTH rather than 0.
    assign level_next = b_next - r_bin;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            // Full when the next write pointer is exactly one lap ahead of
            // the synchronised read pointer: top two Gray bits inverted.
            full        <= (g_next == {~rq[PTR_WIDTH:PTR_WIDTH-1], rq[PTR_WIDTH-2:0]});
            almost_full <= (level_next >= AFULL_LVL);
            wr_level    <= level_next;
            // Setting has priority so a clear racing a fresh overflow
            // cannot hide it.
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
module tb_fifo_wptr_ctrl;

    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] lvl;
        logic       full;
        logic       af;
        logic       ovf;
    } exp_t;

    logic       wclk;
    logic       wrst;
    logic       w_en;
    logic [3:0] g_rptr_async;
    logic       ovf_clr;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t sb_q[$];

    // Reference model state
    logic [3:0] m_b, m_lvl, ms0, ms1;
    logic       m_full, m_af, m_ovf;
    logic [3:0] prev_g;

    fifo_wptr_ctrl #(
        .DEPTH        (8),
        .PTR_WIDTH    (3),
        .AFULL_THRESH (6),
        .SYNC_STAGES  (2)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .w_en         (w_en),
        .g_rptr_async (g_rptr_async),
        .ovf_clr      (ovf_clr),
        .b_wptr       (b_wptr),
        .g_wptr       (g_wptr),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .overflow     (overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of one wclk edge: full means the write side sees a whole lap
    // (DEPTH entries) between write pointer and synchronised read pointer.
    task automatic model_push(input logic rst, input logic we, input logic [3:0] gr, input logic clr);
        exp_t       e;
        logic [3:0] nb;
        logic [3:0] lvl;
        if (rst) begin
            m_b = 0; m_lvl = 0; ms0 = 0; ms1 = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            nb    = m_b + ((we && !m_full) ? 4'd1 : 4'd0);
            lvl   = nb - gray2bin(ms1);
            m_ovf = (we && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_full = (lvl == 4'd8);
            m_af  = (lvl >= 4'd6);
            m_lvl = lvl;
            m_b   = nb;
            ms1   = ms0;
            ms0   = gr;
        end
        e.b = m_b; e.g = bin2gray(m_b); e.lvl = m_lvl;
        e.full = m_full; e.af = m_af; e.ovf = m_ovf;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic we, input logic [3:0] gr, input logic clr);
        exp_t e;
        wrst = rst; w_en = we; g_rptr_async = gr; ovf_clr = clr;
        model_push(rst, we, gr, clr);
        @(posedge wclk);
        #1;
        e = sb_q.pop_front();
        chk("b_wptr",      b_wptr,      e.b);
        chk("g_wptr",      g_wptr,      e.g);
        chk("wr_level",    wr_level,    e.lvl);
        chk("full",        {3'b0, full},        {3'b0, e.full});
        chk("almost_full", {3'b0, almost_full}, {3'b0, e.af});
        chk("overflow",    {3'b0, overflow},    {3'b0, e.ovf});
        if (!rst) begin
            chk("gray_one_bit", {3'b0, ($countones(g_wptr ^ prev_g) <= 1)}, 4'd1);
            chk("level_le_depth", {3'b0, (wr_level <= 4'd8)}, 4'd1);
        end
        prev_g = g_wptr;
    endtask

    initial begin
        int         wraps;
        logic [3:0] rp;
        logic [3:0] g_before;
        wrst = 1'b1; w_en = 1'b0; g_rptr_async = '0; ovf_clr = 1'b0;
        prev_g = '0;

        // Reset state
        step(1, 0, 4'd0, 0);
        chk("rst_b", b_wptr, 4'd0);
        chk("rst_g", g_wptr, 4'd0);
        chk("rst_lvl", wr_level, 4'd0);
        chk("rst_flags", {1'b0, full, almost_full, overflow}, 4'd0);

        // Fill to full
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 4'd0, 0);
            chk("fill_b", b_wptr, 4'(i));
            if (i == 5) chk("af_at5", {3'b0, almost_full}, 4'd0);
            if (i == 6) chk("af_at6", {3'b0, almost_full}, 4'd1);
            if (i == 7) chk("full_at7", {3'b0, full}, 4'd0);
        end
        chk("full_g", g_wptr, 4'b1100);
        chk("full_flag", {3'b0, full}, 4'd1);
        chk("full_lvl", wr_level, 4'd8);

        // Overflow behaviour
        step(0, 1, 4'd0, 0);
        chk("ovf_hold_b", b_wptr, 4'd8);
        chk("ovf_set", {3'b0, overflow}, 4'd1);
        step(0, 0, 4'd0, 1);
        chk("ovf_clr", {3'b0, overflow}, 4'd0);
        step(0, 1, 4'd0, 1);
        chk("ovf_set_wins", {3'b0, overflow}, 4'd1);
        step(0, 0, 4'd0, 1);

        // Read progress takes three edges to reach full/level
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 4'b0001, 0);
            if (i < 3) begin
                chk("rd_early_full", {3'b0, full}, 4'd1);
                chk("rd_early_lvl", wr_level, 4'd8);
            end
        end
        chk("rd_full_drop", {3'b0, full}, 4'd0);
        chk("rd_lvl7", wr_level, 4'd7);

        // Streaming with wrap: the read pointer is driven one ahead of the
        // write pointer so that, after the three-edge transport, the write
        // side sees it two entries behind.
        step(1, 0, 4'd0, 0);
        wraps = 0;
        for (int i = 1; i <= 40; i++) begin
            g_before = g_wptr;
            step(0, 1, bin2gray(m_b + 4'd1), 0);
            if (g_before == 4'b1000 && g_wptr == 4'b0000) wraps++;
            if (i >= 2) begin
                chk("stream_lvl", wr_level, 4'd2);
                chk("stream_full", {3'b0, full}, 4'd0);
            end
        end
        chk("stream_wraps", 4'(wraps), 4'd2);
        chk("stream_b", b_wptr, 4'd8);

        // Reset beats a simultaneous write
        step(1, 0, 4'd0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 4'd0, 0);
        step(1, 1, 4'd0, 0);
        chk("rst_win_b", b_wptr, 4'd0);
        chk("rst_win_flags", {full, almost_full, overflow, |wr_level}, 4'd0);
        step(0, 1, 4'd0, 0);
        chk("post_rst_b", b_wptr, 4'd1);

        // Random traffic; the reader never passes the writer
        step(1, 0, 4'd0, 0);
        rp = '0;
        for (int i = 0; i < 200; i++) begin
            if (rp != m_b && $urandom_range(1, 0) == 1) rp = rp + 4'd1;
            step(0, ($urandom_range(3, 0) != 0), bin2gray(rp), ($urandom_range(7, 0) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
